// File: rtl/lcd_init_sequencer_if.sv
// Bus between write_lcd_block, the init sequencer and the LCD pins.
// The slave side is the sequencer; the master side is the upstream block and the pin observer.
interface lcd_init_sequencer_if;
    logic       RW_in;
    logic       RS_in;
    logic       E_in;
    logic [7:0] data_in;
    logic       RW_lcd;
    logic       RS_lcd;
    logic       E_lcd;
    logic [7:0] data_lcd;
    logic       init_done;

    modport master (
        output RW_in, RS_in, E_in, data_in,
        input  RW_lcd, RS_lcd, E_lcd, data_lcd, init_done
    );

    modport slave (
        input  RW_in, RS_in, E_in, data_in,
        output RW_lcd, RS_lcd, E_lcd, data_lcd, init_done
    );
endinterface

// File: rtl/lcd_init_sequencer.sv
// HD44780 8-bit power-on init sequencer. It owns the LCD pins until the
// command table has been written, then passes write_lcd_block straight through.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// PWR_WAIT | all pins low, power-on settle time
// SETUP    | command byte on data, E low, address setup
// PULSE    | E high, command byte held
// HOLD     | E low, command byte held
// WAIT     | command execution time for the current table entry
// DONE     | init_done high, pins follow the upstream bus
module lcd_init_sequencer #(
    parameter int unsigned T_PWR_CYC   = 750000,
    parameter int unsigned T_SU_CYC    = 2,
    parameter int unsigned T_EW_CYC    = 25,
    parameter int unsigned T_H_CYC     = 2,
    parameter int unsigned T_WAKE1_CYC = 205000,
    parameter int unsigned T_CMD_CYC   = 2500,
    parameter int unsigned T_CLR_CYC   = 100000,
    parameter logic [7:0]  FUNC_SET    = 8'h38,
    parameter logic [7:0]  ENTRY_MODE  = 8'h06,
    parameter logic [7:0]  DISP_CTRL   = 8'h0C
) (
    input logic                  clk,
    input logic                  reset_n,
    lcd_init_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        PWR_WAIT,
        SETUP,
        PULSE,
        HOLD,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    logic [19:0] cnt;
    logic [2:0]  idx;
    logic        e_reg;
    logic [7:0]  data_reg;
    logic        done_reg;

    function automatic logic [7:0] cmd_byte(input logic [2:0] i);
        case (i)
            3'd0, 3'd1, 3'd2: cmd_byte = 8'h30;
            3'd3:             cmd_byte = FUNC_SET;
            3'd4:             cmd_byte = 8'h08;
            3'd5:             cmd_byte = 8'h01;
            3'd6:             cmd_byte = ENTRY_MODE;
            default:          cmd_byte = DISP_CTRL;
        endcase
    endfunction

    // Terminal count (N-1) of the execution wait that follows table entry i.
    function automatic logic [19:0] wait_tc(input logic [2:0] i);
        case (i)
            3'd0:    wait_tc = 20'(T_WAKE1_CYC - 1);
            3'd5:    wait_tc = 20'(T_CLR_CYC - 1);
            default: wait_tc = 20'(T_CMD_CYC - 1);
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= PWR_WAIT;
            cnt      <= '0;
            idx      <= '0;
            e_reg    <= 1'b0;
            data_reg <= 8'h00;
            done_reg <= 1'b0;
        end else begin
            cnt <= cnt + 20'd1;
            case (state)
                PWR_WAIT: if (cnt == 20'(T_PWR_CYC - 1)) begin
                    state    <= SETUP;
                    cnt      <= '0;
                    data_reg <= cmd_byte(idx);
                end
                SETUP: if (cnt == 20'(T_SU_CYC - 1)) begin
                    state <= PULSE;
                    cnt   <= '0;
                    e_reg <= 1'b1;
                end
                PULSE: if (cnt == 20'(T_EW_CYC - 1)) begin
                    state <= HOLD;
                    cnt   <= '0;
                    e_reg <= 1'b0;
                end
                HOLD: if (cnt == 20'(T_H_CYC - 1)) begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: if (cnt == wait_tc(idx)) begin
                    cnt <= '0;
                    if (idx == 3'd7) begin
                        state    <= DONE;
                        done_reg <= 1'b1;
                    end else begin
                        state    <= SETUP;
                        idx      <= idx + 3'd1;
                        data_reg <= cmd_byte(idx + 3'd1);
                    end
                end
                DONE: cnt <= '0;
                default: begin
                    state <= PWR_WAIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // The mux select is a registered state, so E_lcd cannot glitch before DONE.
    assign bus.RW_lcd    = (state == DONE) ? bus.RW_in   : 1'b0;
    assign bus.RS_lcd    = (state == DONE) ? bus.RS_in   : 1'b0;
    assign bus.E_lcd     = (state == DONE) ? bus.E_in    : e_reg;
    assign bus.data_lcd  = (state == DONE) ? bus.data_in : data_reg;
    assign bus.init_done = done_reg;

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Bench for lcd_init_sequencer: captures each E fall against a queue of expected
// command bytes, checks pulse timing, gating, pass-through and async reset.
module tb_lcd_init_sequencer;

    localparam int T_PWR = 100, T_SU = 2, T_EW = 5, T_H = 2;
    localparam int T_WAKE1 = 40, T_CMD = 10, T_CLR = 30;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc;

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;

    lcd_init_sequencer_if ia ();
    lcd_init_sequencer_if ib ();

    lcd_init_sequencer #(
        .T_PWR_CYC(T_PWR), .T_SU_CYC(T_SU), .T_EW_CYC(T_EW), .T_H_CYC(T_H),
        .T_WAKE1_CYC(T_WAKE1), .T_CMD_CYC(T_CMD), .T_CLR_CYC(T_CLR)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(ia.slave)
    );

    lcd_init_sequencer #(
        .T_PWR_CYC(T_PWR), .T_SU_CYC(T_SU), .T_EW_CYC(T_EW), .T_H_CYC(T_H),
        .T_WAKE1_CYC(T_WAKE1), .T_CMD_CYC(T_CMD), .T_CLR_CYC(T_CLR),
        .FUNC_SET(8'h30), .ENTRY_MODE(8'h04), .DISP_CTRL(8'h0F)
    ) dut_ovr (
        .clk(clk), .reset_n(reset_n), .bus(ib.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    // Gap from an E fall to the next E rise: hold, that entry's wait, next setup.
    function automatic int exp_gap(input int i);
        int w;
        w = (i == 0) ? T_WAKE1 : (i == 5) ? T_CLR : T_CMD;
        return T_H + w + T_SU;
    endfunction

    task automatic push_expected();
        logic [7:0] sa[8];
        logic [7:0] sb[8];
        sa = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
        sb = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h08, 8'h01, 8'h04, 8'h0F};
        qa.delete();
        qb.delete();
        for (int i = 0; i < 8; i++) begin
            qa.push_back(sa[i]);
            qb.push_back(sb[i]);
        end
    endtask

    bit prev_e, prev_eb, rs_high, saw41, mon_b_en;
    int pulse_cnt, fall_cnt, rise_cyc, last_fall, first_rise, pulse_cnt_b;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_e     = 1'b0;
            pulse_cnt  = 0;
            fall_cnt   = 0;
            first_rise = -1;
            last_fall  = 0;
        end else if (!ia.init_done) begin
            if (ia.RS_lcd || ia.RW_lcd) rs_high = 1'b1;
            if (ia.data_lcd == 8'h41)   saw41   = 1'b1;
            if (ia.E_lcd && !prev_e) begin
                if (pulse_cnt == 0) first_rise = cyc;
                else check_val("gap", 32'(cyc - last_fall), 32'(exp_gap(pulse_cnt - 1)));
                rise_cyc = cyc;
                pulse_cnt++;
            end
            if (!ia.E_lcd && prev_e) begin
                check_val("e_width", 32'(cyc - rise_cyc), 32'(T_EW));
                fall_cnt++;
                last_fall = cyc;
                if (qa.size() == 0) check_val("extra_pulse", 32'(fall_cnt), 32'(8));
                else check_val("data_at_fall", 32'(ia.data_lcd), 32'(qa.pop_front()));
            end
            prev_e = ia.E_lcd;
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_eb     = 1'b0;
            pulse_cnt_b = 0;
        end else if (mon_b_en && !ib.init_done) begin
            if (!ib.E_lcd && prev_eb) begin
                pulse_cnt_b++;
                if (qb.size() == 0) check_val("ovr_extra_pulse", 32'(pulse_cnt_b), 32'(8));
                else check_val("ovr_data_at_fall", 32'(ib.data_lcd), 32'(qb.pop_front()));
            end
            prev_eb = ib.E_lcd;
        end
    end

    initial begin
        logic [7:0] v;
        rs_high  = 1'b0;
        saw41    = 1'b0;
        mon_b_en = 1'b1;
        ia.RW_in = 1'b0; ia.RS_in = 1'b1; ia.E_in = 1'b1; ia.data_in = 8'h41;
        ib.RW_in = 1'b0; ib.RS_in = 1'b0; ib.E_in = 1'b0; ib.data_in = 8'h00;
        push_expected();

        repeat (3) @(negedge clk);
        check_val("rst_e",    32'(ia.E_lcd),     32'(0));
        check_val("rst_rs",   32'(ia.RS_lcd),    32'(0));
        check_val("rst_rw",   32'(ia.RW_lcd),    32'(0));
        check_val("rst_data", 32'(ia.data_lcd),  32'(0));
        check_val("rst_done", 32'(ia.init_done), 32'(0));
        reset_n = 1'b1;

        for (int i = 0; i < 1000 && !ia.init_done; i++) @(negedge clk);
        check_val("init_done",       32'(ia.init_done), 32'(1));
        check_val("done_cycle",      32'(cyc),          32'(302));
        check_val("first_rise",      32'(first_rise),   32'(T_PWR + T_SU));
        check_val("pulse_count",     32'(pulse_cnt),    32'(8));
        check_val("queue_left",      32'(qa.size()),    32'(0));
        check_val("rs_rw_during",    32'(rs_high),      32'(0));
        check_val("gated_41",        32'(saw41),        32'(0));
        check_val("thru_e",          32'(ia.E_lcd),     32'(1));
        check_val("thru_rs",         32'(ia.RS_lcd),    32'(1));
        check_val("thru_data41",     32'(ia.data_lcd),  32'(8'h41));
        check_val("ovr_done",        32'(ib.init_done), 32'(1));
        check_val("ovr_pulse_count", 32'(pulse_cnt_b),  32'(8));
        check_val("ovr_queue_left",  32'(qb.size()),    32'(0));
        mon_b_en = 1'b0;

        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            v = 8'(i) ^ (i[0] ? 8'hAA : 8'h55);
            ia.data_in = v;
            #1;
            check_val("thru_data", 32'(ia.data_lcd),  32'(v));
            check_val("done_hold", 32'(ia.init_done), 32'(1));
        end

        // Restart, then hit reset in the middle of the fourth E pulse.
        ia.RS_in = 1'b0; ia.E_in = 1'b0; ia.data_in = 8'h00;
        @(negedge clk);
        reset_n = 1'b0;
        push_expected();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 400 && pulse_cnt < 4; i++) @(negedge clk);
        check_val("mid_pulse4_e", 32'(ia.E_lcd), 32'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check_val("async_rst_e",    32'(ia.E_lcd),     32'(0));
        check_val("async_rst_data", 32'(ia.data_lcd),  32'(0));
        check_val("async_rst_done", 32'(ia.init_done), 32'(0));
        push_expected();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 300 && fall_cnt < 1; i++) @(negedge clk);
        check_val("restart_fall",  32'(fall_cnt),   32'(1));
        check_val("restart_rise",  32'(first_rise), 32'(T_PWR + T_SU));
        check_val("restart_queue", 32'(qa.size()),  32'(7));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
